// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default width for the sequential ALU stage.
package alu_pkg;
  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [CW-1:0]    r_cnt;

  // Sum including this step's partial product, so the final edge can hand it out directly.
  assign o_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last = (r_cnt == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH-1);
    end else if (i_step) begin
      r_acc    <= o_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage feeding the G register. Define ALU_MUL_EN for the
// iterative multiplier on opcode 111; otherwise opcode 111 is a move of B.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] A_in,
  input  logic             A_write,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [2:0]       alu_op,
  input  logic             alu_start,
  output logic [WIDTH-1:0] G_in,
  output logic             G_write,
  output logic             alu_busy
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_g_in, w_res;
  logic             w_start, w_is_mul;

  assign w_start  = alu_start && (r_state == S_IDLE);
  assign G_in     = r_g_in;
  assign G_write  = (r_state == S_DONE);
  assign alu_busy = (r_state != S_IDLE);

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_mul_sum;
  logic             w_mul_last;

  assign w_is_mul = (alu_op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock    (clock),
    .resetn   (resetn),
    .i_load   (w_start && w_is_mul),
    .i_step   (r_state == S_MUL),
    .i_mcand  (r_a),
    .i_mplier (bus_in),
    .o_sum    (w_mul_sum),
    .o_last   (w_mul_last)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    case (alu_op)
      OP_ADD: w_res = r_a + bus_in;
      OP_SUB: w_res = r_a - bus_in;
      OP_AND: w_res = r_a & bus_in;
      OP_OR:  w_res = r_a | bus_in;
      OP_XOR: w_res = r_a ^ bus_in;
      OP_SLL: w_res = r_a << bus_in[3:0];
      OP_SRL: w_res = r_a >> bus_in[3:0];
`ifdef ALU_MUL_EN
      default: w_res = '0;
`else
      default: w_res = bus_in;
`endif
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_is_mul ? S_MUL : S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (w_mul_last) w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // A loads in any state; the start path reads r_a, i.e. the pre-edge value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      r_a <= '0;
    else if (A_write) r_a <= A_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                    r_g_in <= '0;
    else if (w_start && !w_is_mul)  r_g_in <= w_res;
`ifdef ALU_MUL_EN
    else if (r_state == S_MUL && w_mul_last) r_g_in <= w_mul_sum;
`endif
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: cycle-level reference model plus literal spot checks.
module tb_alu_seq;
  localparam int W = 16;

  logic          clock = 1'b0;
  logic          resetn;
  logic [W-1:0]  A_in, bus_in, G_in;
  logic          A_write, alu_start, G_write, alu_busy;
  logic [2:0]    alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .A_in(A_in), .A_write(A_write),
    .bus_in(bus_in), .alu_op(alu_op), .alu_start(alu_start),
    .G_in(G_in), .G_write(G_write), .alu_busy(alu_busy)
  );

  always #5 clock = ~clock;

  // Reference model: m_left counts busy cycles still to come, strobe on the last one.
  logic [W-1:0] m_a, m_gin, m_pend;
  int           m_left;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned sh;
    sh = b % 16;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return W'((32'(a) * (2 ** sh)) % (2 ** W));
      3'd6: return W'(32'(a) / (2 ** sh));
      default: begin
`ifdef ALU_MUL_EN
        return W'((32'(a) * 32'(b)) % (2 ** W));
`else
        return b;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_a = '0; m_gin = '0; m_pend = '0; m_left = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 1) m_gin = m_pend;
      end else if (alu_start) begin
        m_pend = ref_op(alu_op, m_a, bus_in);
`ifdef ALU_MUL_EN
        m_left = (alu_op == 3'd7) ? 17 : 1;
`else
        m_left = 1;
`endif
        if (m_left == 1) m_gin = m_pend;
      end
      if (A_write) m_a = A_in;
    end
    #3;
    chk("model G_in", G_in, m_gin);
    chk("model G_write", W'(G_write), W'(m_left == 1));
    chk("model alu_busy", W'(alu_busy), W'(m_left > 0));
    chk("model A", dut.r_a, m_a);
  end

  task automatic load_a(input logic [W-1:0] v);
    @(negedge clock); A_write = 1'b1; A_in = v;
    @(negedge clock); A_write = 1'b0;
  endtask

  // Leaves the bench in the middle of cycle n+1.
  task automatic start(input logic [2:0] op, input logic [W-1:0] b);
    @(negedge clock); alu_start = 1'b1; alu_op = op; bus_in = b;
    @(negedge clock); alu_start = 1'b0;
  endtask

  initial begin
    int first_gw;
    int busy_n;
    resetn = 1'b0; A_in = '0; A_write = 1'b0; bus_in = '0; alu_op = '0; alu_start = 1'b0;
    #12;
    chk("reset G_in", G_in, 16'h0000);
    chk("reset busy", W'(alu_busy), 16'h0);
    @(negedge clock); resetn = 1'b1;

    load_a(16'h0005);
    start(3'd0, 16'h0003);
    chk("add G_in", G_in, 16'h0008);
    chk("add G_write n+1", W'(G_write), 16'h1);
    chk("add busy n+1", W'(alu_busy), 16'h1);
    @(negedge clock);
    chk("add G_write n+2", W'(G_write), 16'h0);
    chk("add busy n+2", W'(alu_busy), 16'h0);

    load_a(16'h0000);
    @(negedge clock); alu_start = 1'b1; alu_op = 3'd1; bus_in = 16'h0001;
    A_write = 1'b1; A_in = 16'h1234;
    @(negedge clock); alu_start = 1'b0; A_write = 1'b0;
    chk("sub wrap", G_in, 16'hFFFF);
    chk("A after same-edge write", dut.r_a, 16'h1234);
    @(negedge clock);
    chk("G_in holds", G_in, 16'hFFFF);

    load_a(16'h8001);
    start(3'd5, 16'h0011);
    chk("sll", G_in, 16'h0002);
    @(negedge clock);
    start(3'd6, 16'h000F);
    chk("srl", G_in, 16'h0001);
    @(negedge clock);
    start(3'd2, 16'h00FF);
    chk("and", G_in, 16'h0001);
    @(negedge clock);
    start(3'd4, 16'hFFFF);
    chk("xor", G_in, 16'h7FFE);
    @(negedge clock);
    start(3'd3, 16'h0F00);
    chk("or", G_in, 16'h8F01);
    @(negedge clock);

`ifdef ALU_MUL_EN
    load_a(16'h0123);
    start(3'd7, 16'h0045);
    first_gw = 0; busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (alu_busy) busy_n++;
      if (G_write && first_gw == 0) first_gw = k;
      if (k == 17) chk("mul G_in", G_in, 16'h4E6F);
      if (k == 3 || k == 10) begin
        alu_start = 1'b1; alu_op = 3'd0; bus_in = 16'h1111;
      end
      @(negedge clock);
      alu_start = 1'b0; alu_op = 3'd7; bus_in = 16'h0045;
    end
    chk("mul strobe cycle", W'(first_gw), 16'd17);
    chk("mul busy cycles", W'(busy_n), 16'd17);
    chk("mul G_in after", G_in, 16'h4E6F);

    start(3'd7, 16'h0003);
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("reset mid-mul G_in", G_in, 16'h0000);
    chk("reset mid-mul busy", W'(alu_busy), 16'h0);
    resetn = 1'b1;
    first_gw = 0;
    for (int k = 0; k < 20; k++) begin
      if (G_write) first_gw++;
      @(negedge clock);
    end
    chk("no G_write after abort", W'(first_gw), 16'd0);
`else
    start(3'd7, 16'hBEEF);
    chk("mv G_in", G_in, 16'hBEEF);
    chk("mv G_write", W'(G_write), 16'h1);
    @(negedge clock);
    chk("mv G_write off", W'(G_write), 16'h0);
    first_gw = 0; busy_n = 0;
    resetn = 1'b0;
    @(negedge clock);
    chk("reset again G_in", G_in, 16'h0000);
    resetn = 1'b1;
`endif
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
